// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared multiply-accumulate stepped over N_TAPS writable
// coefficients per accepted sample, with a registered output and a one-cycle result strobe.
module fir_mac_sequencer #(
    parameter int unsigned N_TAPS  = 4,
    parameter int unsigned BW_in   = 4,
    parameter int unsigned BW_coef = 4,
    parameter int unsigned BW_acc  = 10,
    parameter int unsigned BW_out  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [BW_in-1:0]      x_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         cfg_we,
    input  logic [$clog2(N_TAPS)-1:0]    cfg_addr,
    input  logic signed [BW_coef-1:0]    cfg_data,
    output logic signed [BW_out-1:0]     y_out,
    output logic                         out_valid,
    output logic                         busy
);
    localparam int unsigned AW = $clog2(N_TAPS);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                          state, state_next;
    logic [AW-1:0]                   tap;
    logic signed [BW_acc-1:0]        acc;
    logic signed [BW_in-1:0]         x_dl [N_TAPS];
    logic signed [BW_coef-1:0]       coef [N_TAPS];
    logic signed [BW_in+BW_coef-1:0] prod;
    logic signed [BW_acc-1:0]        prod_ext;
    logic                            last_tap;

    assign prod     = x_dl[tap] * coef[tap];
    assign prod_ext = BW_acc'(prod);
    assign last_tap = (tap == AW'(N_TAPS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = MAC;
            end
            MAC:     if (last_tap) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap       <= '0;
            acc       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < int'(N_TAPS); k++) x_dl[k] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_dl[0] <= x_in;
                        for (int k = 1; k < int'(N_TAPS); k++) x_dl[k] <= x_dl[k-1];
                        acc <= '0;
                        tap <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    tap <= tap + 1'b1;
                end
                DONE: begin
                    y_out     <= acc[BW_acc-1 -: BW_out];
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The MAC reads coef before this edge's write lands, so a same-cycle write takes effect next use.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(N_TAPS); k++) coef[k] <= (k == 0) ? BW_coef'(1) : '0;
        end else if (cfg_we && (32'(cfg_addr) < N_TAPS)) begin
            coef[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench: a dot-product reference model queues expected results, a monitor checks them.
module tb_fir_mac_sequencer;
    localparam int N      = 4;
    localparam int BW_IN  = 4;
    localparam int BW_CO  = 4;
    localparam int BW_ACC = 10;
    localparam int BW_OUT = 8;

    typedef struct {
        logic signed [BW_OUT-1:0] y;
        int                       due;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic signed [BW_IN-1:0]  x_in;
    logic                     in_valid;
    logic                     in_ready;
    logic                     cfg_we;
    logic [1:0]               cfg_addr;
    logic signed [BW_CO-1:0]  cfg_data;
    logic signed [BW_OUT-1:0] y_out;
    logic                     out_valid;
    logic                     busy;

    // Five-tap instance: its 3-bit address can express indices past the last tap.
    logic signed [BW_IN-1:0]  x5;
    logic                     v5, we5, rdy5, vo5, busy5;
    logic [2:0]               addr5;
    logic signed [BW_CO-1:0]  data5;
    logic signed [BW_OUT-1:0] y5;

    int n_vec = 0;
    int n_bad = 0;

    exp_t q[$];
    int   hist[$];
    int   mcoef [N];
    int   snap [N];
    int   cyc = 0;
    int   next_ok = 0;
    int   acc_cyc = 0;
    bit   pend = 1'b0;
    logic signed [BW_OUT-1:0] y_hold = '0;

    always #5 clk = ~clk;

    fir_mac_sequencer #(
        .N_TAPS(N), .BW_in(BW_IN), .BW_coef(BW_CO), .BW_acc(BW_ACC), .BW_out(BW_OUT)
    ) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .y_out(y_out),
        .out_valid(out_valid), .busy(busy)
    );

    fir_mac_sequencer #(
        .N_TAPS(5), .BW_in(BW_IN), .BW_coef(BW_CO), .BW_acc(BW_ACC), .BW_out(BW_OUT)
    ) dut5 (
        .clk(clk), .reset(reset), .x_in(x5), .in_valid(v5), .in_ready(rdy5),
        .cfg_we(we5), .cfg_addr(addr5), .cfg_data(data5), .y_out(y5),
        .out_valid(vo5), .busy(busy5)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: result = sum over taps of (k-th newest sample * coef value seen at that tap's edge),
    // wrapped to the accumulator width; a sample is taken only N+2 cycles after the previous one.
    always @(posedge clk or negedge reset) begin : model
        int s;
        logic [BW_ACC-1:0] w;
        exp_t e;
        if (!reset) begin
            q.delete();
            hist.delete();
            pend    = 1'b0;
            next_ok = 0;
            for (int k = 0; k < N; k++) mcoef[k] = (k == 0) ? 1 : 0;
        end else begin
            cyc++;
            if (pend && cyc > acc_cyc && cyc <= acc_cyc + N)
                snap[cyc-acc_cyc-1] = mcoef[cyc-acc_cyc-1];
            if (pend && cyc == acc_cyc + N) begin
                s = 0;
                for (int k = 0; k < N; k++) if (k < hist.size()) s += hist[k] * snap[k];
                w     = s[BW_ACC-1:0];
                e.y   = w[BW_ACC-1 -: BW_OUT];
                e.due = acc_cyc + N + 1;
                q.push_back(e);
                pend = 1'b0;
            end
            if (cyc >= next_ok && in_valid) begin
                hist.push_front(int'(x_in));
                if (hist.size() > N) void'(hist.pop_back());
                acc_cyc = cyc;
                next_ok = cyc + N + 2;
                pend    = 1'b1;
            end
            if (cfg_we) mcoef[cfg_addr] = int'(cfg_data);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            y_hold = '0;
            check("rst_out_valid", out_valid, 0);
            check("rst_y_out", y_out, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_busy", busy, 0);
        end else begin
            check("in_ready", in_ready, (cyc + 1 >= next_ok) ? 1 : 0);
            check("busy", busy, (cyc + 1 >= next_ok) ? 0 : 1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("out_valid_cycle", cyc, e.due);
                    check("y_result", y_out, e.y);
                    y_hold = e.y;
                end
            end else if (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                check("missing_out_valid", out_valid, 1);
            end
            check("y_held", y_out, y_hold);
        end
    end

    task automatic drive(input int v, input int x, input int we, input int a, input int d);
        in_valid = v[0];
        x_in     = BW_IN'(x);
        cfg_we   = we[0];
        cfg_addr = 2'(a);
        cfg_data = BW_CO'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bit got;
        in_valid = 0; x_in = '0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
        x5 = '0; v5 = 0; we5 = 0; addr5 = '0; data5 = '0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Pass-through defaults: 4 -> 1, then -8 -> -2.
        drive(1, 4, 0, 0, 0);
        idle(N + 4);
        drive(1, -8, 0, 0, 0);
        idle(N + 4);

        // Coefs 1..4 with in_valid held high: results 1, 3, 6, 10.
        pulse_reset();
        for (int k = 0; k < N; k++) drive(0, 0, 1, k, k + 1);
        for (int i = 0; i < 4 * (N + 2); i++) drive(1, 4, 0, 0, 0);
        idle(N + 4);

        // in_valid held with x changing every cycle; only IDLE-cycle values count.
        for (int i = 0; i < 40; i++) drive(1, int'($urandom_range(15)), 0, 0, 0);
        idle(N + 4);

        // Reset while tap==2 aborts the result and restores pass-through.
        drive(0, 0, 1, 0, 3);
        drive(1, 5, 0, 0, 0);
        idle(2);
        pulse_reset();
        drive(1, 4, 0, 0, 0);
        idle(N + 4);

        // Rewrite coef[3] while the MAC is on tap 3: old value now, new value next sample.
        drive(0, 0, 1, 3, 2);
        for (int i = 0; i < 3; i++) begin
            drive(1, i + 2, 0, 0, 0);
            idle(N + 1);
        end
        drive(1, 3, 0, 0, 0);
        idle(3);
        drive(0, 0, 1, 3, -3);
        idle(N);
        drive(1, 1, 0, 0, 0);
        idle(N + 4);

        // Random traffic, including writes landing alongside accepts.
        for (int i = 0; i < 200; i++)
            drive(int'($urandom_range(1)), int'($urandom_range(15)),
                  ($urandom_range(3) == 0) ? 1 : 0, int'($urandom_range(3)),
                  int'($urandom_range(15)));
        idle(N + 4);

        // Writes to addresses 5..7 of the five-tap instance must leave pass-through intact.
        for (int a = 5; a < 8; a++) begin
            we5 = 1; addr5 = 3'(a); data5 = BW_CO'(7);
            @(posedge clk);
            #1;
        end
        we5 = 0; x5 = BW_IN'(4); v5 = 1;
        @(posedge clk);
        #1;
        v5 = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (vo5) begin
                got = 1;
                check("oor_write_y", y5, 1);
            end
        end
        check("oor_result_seen", got, 1);

        idle(N + 4);
        check("outstanding_results", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
